// File: rtl/decode_pkg.sv
// Shared opcode encodings, memory-size codes and the decoded payload record
// used by the decode stage and its combinational decoder.
package decode_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    localparam logic [1:0] MEM_BYTE   = 2'd0;
    localparam logic [1:0] MEM_HALF   = 2'd1;
    localparam logic [1:0] MEM_WORD   = 2'd2;
    localparam logic [1:0] MEM_DOUBLE = 2'd3;

    // imm is held at the widest datapath; narrower stages use the low bits
    typedef struct packed {
        logic [6:0]  alu_op;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alu_src;
        logic        pc_src;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        illegal;
    } decoded_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/payload bundle of the decode stage.
interface decode_stage_if #(
    parameter int XLEN            = 64,
    parameter int INSTR_WIDTH     = 32,
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7,
    parameter int REG_ID_WIDTH    = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [INSTR_WIDTH-1:0]     in_instr;
    logic [XLEN-1:0]            in_pc;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_pc;
    logic [ALU_OP_WIDTH-1:0]    alu_op;
    logic [ALU_FUNC3_WIDTH-1:0] func3;
    logic [ALU_FUNC7_WIDTH-1:0] func7;
    logic [XLEN-1:0]            imm;
    logic [REG_ID_WIDTH-1:0]    rs1;
    logic [REG_ID_WIDTH-1:0]    rs2;
    logic [REG_ID_WIDTH-1:0]    rd;
    logic                       alu_src;
    logic                       pc_src;
    logic                       mem_read;
    logic                       mem_write;
    logic [1:0]                 mem_size;
    logic                       mem_unsigned;
    logic                       reg_write;
    logic                       mem_to_reg;
    logic                       branch;
    logic                       jump;
    logic                       illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, alu_op, func3, func7, imm, rs1, rs2, rd,
               alu_src, pc_src, mem_read, mem_write, mem_size, mem_unsigned,
               reg_write, mem_to_reg, branch, jump, illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, alu_op, func3, func7, imm, rs1, rs2, rd,
               alu_src, pc_src, mem_read, mem_write, mem_size, mem_unsigned,
               reg_write, mem_to_reg, branch, jump, illegal
    );
endinterface

// File: rtl/decode_logic.sv
// Purely combinational RV32/RV64 instruction decoder: instruction word to
// register IDs, sign-extended immediate, func fields and control flags.
module decode_logic
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] instr,
    output decoded_t    dec
);
    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode_s;
    logic [2:0]  f3_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [63:0] imm_i_s;
    logic [63:0] imm_s_s;
    logic [63:0] imm_b_s;
    logic [63:0] imm_u_s;
    logic [63:0] imm_j_s;
    logic        is_shift_s;
    logic        bad_s;
    decoded_t    raw_s;

    assign opcode_s   = instr[6:0];
    assign f3_s       = instr[14:12];
    assign rd_s       = instr[11:7];
    assign rs1_s      = instr[19:15];
    assign rs2_s      = instr[24:20];
    assign is_shift_s = (f3_s[1:0] == 2'b01);
    assign imm_i_s    = sext32({{20{instr[31]}}, instr[31:20]});
    assign imm_s_s    = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
    assign imm_b_s    = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
    assign imm_u_s    = sext32({instr[31:12], 12'h000});
    assign imm_j_s    = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});

    // Per-opcode field extraction, raw control flags and legality
    always_comb begin
        raw_s        = '0;
        bad_s        = 1'b0;
        raw_s.alu_op = opcode_s;
        case (opcode_s)
            OP, OP_32: begin
                {raw_s.rd, raw_s.rs1, raw_s.rs2} = {rd_s, rs1_s, rs2_s};
                raw_s.func3      = f3_s;
                raw_s.func7      = instr[31:25];
                raw_s.reg_write  = 1'b1;
                raw_s.mem_to_reg = 1'b1;
                bad_s            = (opcode_s == OP_32) && !RV64;
            end
            OP_IMM, OP_IMM_32: begin
                {raw_s.rd, raw_s.rs1} = {rd_s, rs1_s};
                raw_s.func3      = f3_s;
                raw_s.imm        = imm_i_s;
                raw_s.alu_src    = 1'b1;
                raw_s.reg_write  = 1'b1;
                raw_s.mem_to_reg = 1'b1;
                // 64-bit OP-IMM shifts borrow instr[25] as shamt[5]
                if (!is_shift_s) begin
                    raw_s.func7 = 7'd0;
                end else if (RV64 && (opcode_s == OP_IMM)) begin
                    raw_s.func7 = {instr[31:26], 1'b0};
                end else begin
                    raw_s.func7 = instr[31:25];
                end
                bad_s = !RV64 && ((opcode_s == OP_IMM_32) || (is_shift_s && instr[25]));
            end
            LOAD: begin
                {raw_s.rd, raw_s.rs1} = {rd_s, rs1_s};
                raw_s.func3        = f3_s;
                raw_s.imm          = imm_i_s;
                raw_s.alu_src      = 1'b1;
                raw_s.mem_read     = 1'b1;
                raw_s.reg_write    = 1'b1;
                raw_s.mem_size     = f3_s[1:0];
                raw_s.mem_unsigned = f3_s[2];
                bad_s = (f3_s == 3'b111) || (!RV64 && ((f3_s == 3'b011) || (f3_s == 3'b110)));
            end
            STORE: begin
                {raw_s.rs1, raw_s.rs2} = {rs1_s, rs2_s};
                raw_s.func3     = f3_s;
                raw_s.imm       = imm_s_s;
                raw_s.alu_src   = 1'b1;
                raw_s.mem_write = 1'b1;
                raw_s.mem_size  = f3_s[1:0];
                bad_s = f3_s[2] || (!RV64 && (f3_s == 3'b011));
            end
            BRANCH: begin
                {raw_s.rs1, raw_s.rs2} = {rs1_s, rs2_s};
                raw_s.func3  = f3_s;
                raw_s.imm    = imm_b_s;
                raw_s.branch = 1'b1;
                bad_s        = (f3_s[2:1] == 2'b01);
            end
            JAL: begin
                raw_s.rd         = rd_s;
                raw_s.imm        = imm_j_s;
                raw_s.alu_src    = 1'b1;
                raw_s.pc_src     = 1'b1;
                raw_s.jump       = 1'b1;
                raw_s.reg_write  = 1'b1;
                raw_s.mem_to_reg = 1'b1;
            end
            JALR: begin
                {raw_s.rd, raw_s.rs1} = {rd_s, rs1_s};
                raw_s.func3      = f3_s;
                raw_s.imm        = imm_i_s;
                raw_s.alu_src    = 1'b1;
                raw_s.jump       = 1'b1;
                raw_s.reg_write  = 1'b1;
                raw_s.mem_to_reg = 1'b1;
            end
            LUI, AUIPC: begin
                raw_s.rd         = rd_s;
                raw_s.imm        = imm_u_s;
                raw_s.alu_src    = 1'b1;
                raw_s.pc_src     = (opcode_s == AUIPC);
                raw_s.reg_write  = 1'b1;
                raw_s.mem_to_reg = 1'b1;
            end
            SYSTEM: begin
                {raw_s.rd, raw_s.rs1} = {rd_s, rs1_s};
                raw_s.func3      = f3_s;
                raw_s.imm        = imm_i_s;
                raw_s.alu_src    = 1'b1;
                raw_s.reg_write  = (f3_s != 3'b000);
                raw_s.mem_to_reg = 1'b1;
            end
            default: begin
                bad_s = 1'b1;
            end
        endcase
    end

    // Suppress architectural side effects of illegal encodings and x0 writes
    always_comb begin
        dec           = raw_s;
        dec.illegal   = bad_s;
        dec.reg_write = raw_s.reg_write && (raw_s.rd != 5'd0) && !bad_s;
        dec.mem_read  = raw_s.mem_read && !bad_s;
        dec.mem_write = raw_s.mem_write && !bad_s;
        dec.branch    = raw_s.branch && !bad_s;
        dec.jump      = raw_s.jump && !bad_s;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: combinational decode feeding a 2-entry skid buffer
// so upstream ready never depends on downstream ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int INSTR_WIDTH     = 32,
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7,
    parameter int REG_ID_WIDTH    = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    decode_stage_if.slave  bus
);
    decoded_t        dec_s;
    decoded_t        head_r;
    decoded_t        tail_r;
    logic [XLEN-1:0] head_pc_r;
    logic [XLEN-1:0] tail_pc_r;
    logic [1:0]      count_r;
    logic            push_s;
    logic            pop_s;

    decode_logic #(.XLEN(XLEN)) u_decode (
        .instr (bus.in_instr[31:0]),
        .dec   (dec_s)
    );

    assign bus.in_ready  = rst_n && !flush && (count_r != 2'd2);
    assign bus.out_valid = !flush && (count_r != 2'd0);
    assign push_s        = bus.in_valid && bus.in_ready;
    assign pop_s         = bus.out_valid && bus.out_ready;

    // Skid buffer: head is always the oldest entry; tail only holds the second
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r   <= 2'd0;
            head_r    <= '0;
            tail_r    <= '0;
            head_pc_r <= '0;
            tail_pc_r <= '0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r    <= dec_s;
                        head_pc_r <= bus.in_pc;
                    end else begin
                        tail_r    <= dec_s;
                        tail_pc_r <= bus.in_pc;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r    <= tail_r;
                    head_pc_r <= tail_pc_r;
                    count_r   <= count_r - 2'd1;
                end
                // Both handshakes only coincide at count 1: new entry replaces head
                2'b11: begin
                    head_r    <= dec_s;
                    head_pc_r <= bus.in_pc;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign bus.out_pc       = head_pc_r;
    assign bus.alu_op       = head_r.alu_op;
    assign bus.func3        = head_r.func3;
    assign bus.func7        = head_r.func7;
    assign bus.imm          = head_r.imm[XLEN-1:0];
    assign bus.rs1          = head_r.rs1;
    assign bus.rs2          = head_r.rs2;
    assign bus.rd           = head_r.rd;
    assign bus.alu_src      = head_r.alu_src;
    assign bus.pc_src       = head_r.pc_src;
    assign bus.mem_read     = head_r.mem_read;
    assign bus.mem_write    = head_r.mem_write;
    assign bus.mem_size     = head_r.mem_size;
    assign bus.mem_unsigned = head_r.mem_unsigned;
    assign bus.reg_write    = head_r.reg_write;
    assign bus.mem_to_reg   = head_r.mem_to_reg;
    assign bus.branch       = head_r.branch;
    assign bus.jump         = head_r.jump;
    assign bus.illegal      = head_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Drives an RV64 and an RV32 decode stage with identical stimulus and checks
// both against a queue-based reference model of the stage.
module tb_decode_stage;

    localparam logic [6:0] T_OP = 7'h33, T_OP32 = 7'h3B, T_OPIMM = 7'h13, T_OPIMM32 = 7'h1B;
    localparam logic [6:0] T_LOAD = 7'h03, T_STORE = 7'h23, T_BRANCH = 7'h63, T_JAL = 7'h6F;
    localparam logic [6:0] T_JALR = 7'h67, T_LUI = 7'h37, T_AUIPC = 7'h17, T_SYSTEM = 7'h73;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        alu_src, pc_src, mem_read, mem_write;
        logic [1:0]  mem_size;
        logic        mem_unsigned, reg_write, mem_to_reg, branch, jump, illegal;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(64)) bus64 ();
    decode_stage_if #(.XLEN(32)) bus32 ();

    decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64));
    decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32));

    int   checks = 0;
    int   failures = 0;
    ent_t q64[$];
    ent_t q32[$];
    bit   zero_payload;
    ent_t obs64, obs32;

    always_comb begin
        obs64 = '0;
        obs64.pc = bus64.out_pc;          obs64.op = bus64.alu_op;
        obs64.f3 = bus64.func3;           obs64.f7 = bus64.func7;
        obs64.imm = bus64.imm;            obs64.rs1 = bus64.rs1;
        obs64.rs2 = bus64.rs2;            obs64.rd = bus64.rd;
        obs64.alu_src = bus64.alu_src;    obs64.pc_src = bus64.pc_src;
        obs64.mem_read = bus64.mem_read;  obs64.mem_write = bus64.mem_write;
        obs64.mem_size = bus64.mem_size;  obs64.mem_unsigned = bus64.mem_unsigned;
        obs64.reg_write = bus64.reg_write; obs64.mem_to_reg = bus64.mem_to_reg;
        obs64.branch = bus64.branch;      obs64.jump = bus64.jump;
        obs64.illegal = bus64.illegal;
        obs32 = '0;
        obs32.pc = {32'h0, bus32.out_pc}; obs32.op = bus32.alu_op;
        obs32.f3 = bus32.func3;           obs32.f7 = bus32.func7;
        obs32.imm = {32'h0, bus32.imm};   obs32.rs1 = bus32.rs1;
        obs32.rs2 = bus32.rs2;            obs32.rd = bus32.rd;
        obs32.alu_src = bus32.alu_src;    obs32.pc_src = bus32.pc_src;
        obs32.mem_read = bus32.mem_read;  obs32.mem_write = bus32.mem_write;
        obs32.mem_size = bus32.mem_size;  obs32.mem_unsigned = bus32.mem_unsigned;
        obs32.reg_write = bus32.reg_write; obs32.mem_to_reg = bus32.mem_to_reg;
        obs32.branch = bus32.branch;      obs32.jump = bus32.jump;
        obs32.illegal = bus32.illegal;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA immediate/format rules
    function automatic ent_t ref_decode(input logic [31:0] ins, input logic [63:0] pc, input bit rv64);
        ent_t   e;
        longint si, imm;
        logic [6:0] op;
        logic [2:0] f3;
        byte    fmt;
        bit     shift, bad, rw;
        e   = '0;
        op  = ins[6:0];
        f3  = ins[14:12];
        si  = longint'($signed(ins));
        imm = 0;
        case (op)
            T_OP, T_OP32:                                fmt = "R";
            T_OPIMM, T_OPIMM32, T_LOAD, T_JALR, T_SYSTEM: fmt = "I";
            T_STORE:                                     fmt = "S";
            T_BRANCH:                                    fmt = "B";
            T_LUI, T_AUIPC:                              fmt = "U";
            T_JAL:                                       fmt = "J";
            default:                                     fmt = "X";
        endcase
        e.op = op;
        case (fmt)
            "R": begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = f3; e.f7 = ins[31:25]; end
            "I": begin e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.f3 = f3; imm = si >>> 20; end
            "S": begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = f3;
                       imm = ((si >>> 25) <<< 5) | longint'(ins[11:7]); end
            "B": begin e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.f3 = f3;
                       imm = ((si >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                           | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1); end
            "U": begin e.rd = ins[11:7]; imm = (si >>> 12) <<< 12; end
            "J": begin e.rd = ins[11:7];
                       imm = ((si >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                           | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1); end
            default: imm = 0;
        endcase
        shift = (op == T_OPIMM || op == T_OPIMM32) && (f3 == 3'd1 || f3 == 3'd5);
        if (shift) e.f7 = (rv64 && op == T_OPIMM) ? {ins[31:26], 1'b0} : ins[31:25];
        e.alu_src      = (fmt == "I" || fmt == "S" || fmt == "U" || fmt == "J");
        e.pc_src       = (op == T_AUIPC || op == T_JAL);
        e.mem_size     = (op == T_LOAD || op == T_STORE) ? f3[1:0] : 2'd0;
        e.mem_unsigned = (op == T_LOAD) ? f3[2] : 1'b0;
        e.mem_to_reg   = op inside {T_OP, T_OP32, T_OPIMM, T_OPIMM32, T_JAL, T_JALR, T_LUI, T_AUIPC, T_SYSTEM};
        rw  = (op inside {T_OP, T_OP32, T_OPIMM, T_OPIMM32, T_LOAD, T_JAL, T_JALR, T_LUI, T_AUIPC})
            || (op == T_SYSTEM && f3 != 3'd0);
        bad = (fmt == "X")
            || (op == T_BRANCH && (f3 == 3'd2 || f3 == 3'd3))
            || (op == T_LOAD && (f3 == 3'd7 || (!rv64 && (f3 == 3'd3 || f3 == 3'd6))))
            || (op == T_STORE && (f3 >= 3'd4 || (!rv64 && f3 == 3'd3)))
            || (!rv64 && (op == T_OP32 || op == T_OPIMM32))
            || (!rv64 && op == T_OPIMM && shift && ins[25]);
        e.illegal   = bad;
        e.mem_read  = (op == T_LOAD) && !bad;
        e.mem_write = (op == T_STORE) && !bad;
        e.branch    = (op == T_BRANCH) && !bad;
        e.jump      = (op == T_JAL || op == T_JALR) && !bad;
        e.reg_write = rw && (e.rd != 5'd0) && !bad;
        e.imm       = rv64 ? imm : {32'h0, imm[31:0]};
        e.pc        = rv64 ? pc : {32'h0, pc[31:0]};
        return e;
    endfunction

    task automatic compare_entry(input string who, input ent_t obs, input ent_t exp);
        check_eq({who, ".pc"}, obs.pc, exp.pc);
        check_eq({who, ".alu_op"}, 64'(obs.op), 64'(exp.op));
        check_eq({who, ".func3"}, 64'(obs.f3), 64'(exp.f3));
        check_eq({who, ".func7"}, 64'(obs.f7), 64'(exp.f7));
        check_eq({who, ".imm"}, obs.imm, exp.imm);
        check_eq({who, ".regs"}, 64'({obs.rs1, obs.rs2, obs.rd}), 64'({exp.rs1, exp.rs2, exp.rd}));
        check_eq({who, ".ctrl"},
                 64'({obs.alu_src, obs.pc_src, obs.mem_read, obs.mem_write, obs.mem_size, obs.mem_unsigned,
                      obs.reg_write, obs.mem_to_reg, obs.branch, obs.jump, obs.illegal}),
                 64'({exp.alu_src, exp.pc_src, exp.mem_read, exp.mem_write, exp.mem_size, exp.mem_unsigned,
                      exp.reg_write, exp.mem_to_reg, exp.branch, exp.jump, exp.illegal}));
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model at the rising edge
    task automatic cycle(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                         input bit ordy, input bit fl, input bit rn);
        bit exp_ir, exp_ov, acc, pop;
        rst_n = rn;
        flush = fl;
        bus64.in_valid = v;    bus32.in_valid = v;
        bus64.in_instr = ins;  bus32.in_instr = ins;
        bus64.in_pc = pc;      bus32.in_pc = pc[31:0];
        bus64.out_ready = ordy; bus32.out_ready = ordy;
        @(negedge clk);
        exp_ir = rn && !fl && (q64.size() != 2);
        exp_ov = !fl && (q64.size() != 0);
        check_eq("in_ready64", 64'(bus64.in_ready), 64'(exp_ir));
        check_eq("in_ready32", 64'(bus32.in_ready), 64'(exp_ir));
        check_eq("out_valid64", 64'(bus64.out_valid), 64'(exp_ov));
        check_eq("out_valid32", 64'(bus32.out_valid), 64'(exp_ov));
        if (q64.size() != 0) begin
            compare_entry("head64", obs64, q64[0]);
            compare_entry("head32", obs32, q32[0]);
        end else if (zero_payload) begin
            compare_entry("rst64", obs64, '0);
            compare_entry("rst32", obs32, '0);
        end
        acc = exp_ir && v;
        pop = exp_ov && ordy;
        @(posedge clk);
        if (!rn) begin
            q64.delete(); q32.delete(); zero_payload = 1'b1;
        end else if (fl) begin
            q64.delete(); q32.delete();
        end else begin
            if (pop) begin void'(q64.pop_front()); void'(q32.pop_front()); end
            if (acc) begin
                q64.push_back(ref_decode(ins, pc, 1'b1));
                q32.push_back(ref_decode(ins, pc, 1'b0));
                zero_payload = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [12] = '{T_OP, T_OP32, T_OPIMM, T_OPIMM32, T_LOAD, T_STORE,
                                  T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC, T_SYSTEM};
        logic [31:0] w;
        w = $urandom();
        if ($urandom_range(0, 7) == 0) return w;
        w[6:0] = ops[$urandom_range(0, 11)];
        return w;
    endfunction

    initial begin
        logic [63:0] pc;
        rst_n = 1'b0; flush = 1'b0;
        bus64.in_valid = 1'b0; bus32.in_valid = 1'b0;
        bus64.in_instr = 32'h0; bus32.in_instr = 32'h0;
        bus64.in_pc = 64'h0; bus32.in_pc = 32'h0;
        bus64.out_ready = 1'b0; bus32.out_ready = 1'b0;
        zero_payload = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 32'hFFF10093, 64'h100, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // Anchored expectations for the documented encodings
        cycle(1'b1, 32'hFFF10093, 64'h8000_0000_0000_1000, 1'b0, 1'b0, 1'b1);
        check_eq("addi_imm", bus64.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("addi_rd_rs1", 64'({bus64.rd, bus64.rs1}), 64'({5'd1, 5'd2}));
        check_eq("addi_ctrl", 64'({bus64.alu_src, bus64.reg_write, bus64.mem_to_reg}), 64'(3'b111));
        cycle(1'b1, 32'h00853283, 64'h1004, 1'b1, 1'b0, 1'b1);
        check_eq("ld64_ctrl", 64'({bus64.mem_read, bus64.mem_size, bus64.mem_to_reg}), 64'({1'b1, 2'd3, 1'b0}));
        check_eq("ld64_imm", bus64.imm, 64'd8);
        check_eq("ld32_ctrl", 64'({bus32.illegal, bus32.mem_read, bus32.reg_write}), 64'(3'b100));
        cycle(1'b1, 32'h00000013, 64'h1008, 1'b1, 1'b0, 1'b1);
        check_eq("nop_ctrl", 64'({bus64.reg_write, bus64.illegal, bus32.reg_write, bus32.illegal}), 64'd0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // Back-pressure: third push must wait, then all drain in order
        cycle(1'b1, 32'h00208033, 64'h2000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0040A103, 64'h2004, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h00312423, 64'h2008, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h00312423, 64'h2008, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // Flush while full with a pending input
        cycle(1'b1, 32'h000000EF, 64'h3000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h00C000E7, 64'h3004, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h12345037, 64'h3008, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        // Reset with one entry buffered
        cycle(1'b1, 32'hFE5FF06F, 64'h4000, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            pc = {$urandom(), $urandom()};
            cycle($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 199) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32/RV64 instruction decode stage that sits between fetch and execute. It accepts instruction/PC pairs over a valid/ready handshake and decodes them into register IDs, a sign-extended immediate, func fields and the full control-signal set, including memory size/sign, PC-as-operand, branch/jump and illegal-instruction flags. Results are held in a 2-entry skid buffer, so `in_ready` never depends combinationally on `out_ready`, and the stage sustains one instruction per cycle.

## Interface
Parameters:
- `XLEN`, 64: datapath width; only 32 or 64 are legal. Sets the `imm` and PC width, and gates the RV64-only opcodes.
- `INSTR_WIDTH`, 32: instruction width.
- `ALU_OP_WIDTH`, 7 / `ALU_FUNC3_WIDTH`, 3 / `ALU_FUNC7_WIDTH`, 7: opcode and func field widths.
- `REG_ID_WIDTH`, 5: register index width.

Ports:
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `flush`  in  1  discard all buffered entries.
- `in_valid` in 1, `in_ready` out 1: upstream handshake.
- `in_instr`  in  INSTR_WIDTH  instruction word.
- `in_pc`  in  XLEN  instruction PC.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_pc`  out  XLEN  PC of the head entry.
- `alu_op`  out  ALU_OP_WIDTH  opcode field (`instr[6:0]`).
- `func3`  out  ALU_FUNC3_WIDTH  func3 field.
- `func7`  out  ALU_FUNC7_WIDTH  func7 field.
- `imm`  out  XLEN  immediate, sign-extended to XLEN.
- `rs1`, `rs2`, `rd`  out  REG_ID_WIDTH each  register IDs.
- `alu_src`  out  1  ALU operand B select: 1 = immediate.
- `pc_src`  out  1  ALU operand A select: 1 = PC (auipc, jal).
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable.
- `mem_size`  out  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- `mem_unsigned`  out  1  zero-extend loaded data.
- `reg_write`  out  1  register write enable.
- `mem_to_reg`  out  1  writeback source: 0 = memory, 1 = ALU result.
- `branch`  out  1  conditional branch.
- `jump`  out  1  jal or jalr.
- `illegal`  out  1  illegal instruction.

## Operation
- Decode is combinational on `in_instr`. The decoded result is written into the buffer on an input handshake (`in_valid && in_ready`).
- The buffer is a 2-entry FIFO tracked by `count` (0, 1 or 2).
  - `in_ready = rst_n && !flush && count != 2`.
  - `out_valid = !flush && count != 0`.
  - All payload outputs show the head entry.
- Field extraction per format:
  - R, I, S, B, J and U formats extract fields per the RISC-V base ISA. Unused fields are 0.
  - U-type `imm` is `{sext(instr[31]), instr[31:12], 12'b0}`.
  - For OP-IMM shifts: with XLEN=64, `func7 = {instr[31:26], 1'b0}` and `imm[5:0]` is the shift amount. With XLEN=32, `func7 = instr[31:25]`.
- Control signal rules:
  - `mem_size = func3[1:0]` and `mem_unsigned = func3[2]` for loads. Stores use `mem_size = func3[1:0]` with `mem_unsigned = 0`.
  - `pc_src = 1` for auipc and jal. `jump = 1` for jal and jalr. `branch = 1` for opcode 1100011.
  - When `rd == 0`, `reg_write` is forced to 0.
- `illegal` is set for:
  - an unknown opcode;
  - branch func3 of 010 or 011;
  - load func3 of 111, or of 011/110 when XLEN=32;
  - store func3 ≥ 100, or of 011 when XLEN=32;
  - opcodes 0111011 or 0011011 when XLEN=32;
  - an RV32 shift with `instr[25]` set.
- When `illegal` is set, `mem_read`, `mem_write`, `reg_write`, `branch` and `jump` are forced to 0. The entry is still passed downstream with its `out_pc`.

## Timing
- Reset (`rst_n` low at a rising edge): `count` = 0, every payload register = 0, `out_valid` = 0, `in_ready` = 0 while `rst_n` is low. `in_ready` returns to 1 in the first cycle after reset is released. Reset mid-operation drops all entries.
- Latency: an instruction accepted in cycle N with `count` = 0 is presented with `out_valid` = 1 in cycle N+1. Throughput is 1 per cycle while `out_ready` = 1.
- Simultaneous input and output handshakes with `count` = 1: `count` stays 1 and the new entry becomes the head in the next cycle.
- `count` = 2: `in_ready` = 0. An output handshake moves `count` to 1.
- Ordering: entries leave in arrival order.
- `flush` has priority over both handshakes. No transfer occurs in the flush cycle, and `count` = 0 in the next cycle.
- `out_*` payload is stable while `out_valid && !out_ready`.

## Structure
- Package `decode_pkg` holds:
  - the opcode localparams (OP, OP_32, OP_IMM, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - the `mem_size` encodings;
  - `decoded_t`, a packed struct of all payload fields.
- Sub-module `decode_logic`: purely combinational, maps `instr` to `decoded_t`, parametrised by XLEN. `decode_stage` contains only the skid buffer and the handshake logic.

## Test plan
- addi x1,x2,-1 (0xFFF10093), XLEN=64 → next cycle: `imm` = 0xFFFFFFFFFFFFFFFF, `rd` = 1, `rs1` = 2, `alu_src` = 1, `reg_write` = 1, `mem_to_reg` = 1.
- ld x5,8(x10) (0x00853283) → XLEN=64: `mem_read` = 1, `mem_size` = 3, `imm` = 8, `mem_to_reg` = 0. XLEN=32: `illegal` = 1, `mem_read` = 0, `reg_write` = 0.
- addi x0,x0,0 (0x00000013) → `reg_write` = 0, `illegal` = 0.
- Hold `out_ready` = 0 and push 3 instructions back-to-back → `in_ready` = 0 after 2 accepts. Release `out_ready` → the 3 instructions emerge in order, one per cycle.
- `count` = 2, assert `flush` with `in_valid` = 1 → no transfer that cycle. Next cycle: `out_valid` = 0, `in_ready` = 1.
- Drop `rst_n` for one cycle while `count` = 1 → `out_valid` = 0 and all payload = 0 in the cycle after the reset edge.
